// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - two-requester memory port bundle for data_mem_arbiter
interface data_mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter for two requesters sharing one word memory
module data_mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                sys_rst,
    data_mem_arbiter_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              win;
    logic              win_nxt;
    logic              last;
    logic              grant_en;
    logic              mem_we;
    logic              rd_en;
    logic              done;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        grant_en  = 1'b0;
        mem_we    = 1'b0;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nxt = ACCESS;
                    grant_en  = 1'b1;
                    // On contention the requester that was not served last wins
                    if (bus.req0 && bus.req1) begin
                        win_nxt = ~last;
                    end else begin
                        win_nxt = bus.req1;
                    end
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                mem_we    = lat_we;
                rd_en     = ~lat_we;
            end
            RESP: begin
                state_nxt = IDLE;
                done      = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            win       <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            ack0_q <= (state == ACCESS) && !win;
            ack1_q <= (state == ACCESS) && win;
            if (grant_en) begin
                win       <= win_nxt;
                lat_we    <= win_nxt ? bus.we1    : bus.we0;
                lat_addr  <= win_nxt ? bus.addr1  : bus.addr0;
                lat_wdata <= win_nxt ? bus.wdata1 : bus.wdata0;
                gnt0_q    <= ~win_nxt;
                gnt1_q    <= win_nxt;
            end
            if (rd_en) begin
                if (win) begin
                    rdata1_q <= mem[lat_addr];
                end else begin
                    rdata0_q <= mem[lat_addr];
                end
            end
            if (done) begin
                gnt0_q <= 1'b0;
                gnt1_q <= 1'b0;
                last   <= win;
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
    assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int N_RAND = 10000;

    typedef struct {
        bit              port;
        bit              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_rd0;
    logic [DATA_W-1:0] exp_rd1;
    bit                last_served;
    vec_t              vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = 1'b0;  bus.we1 = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ctl"}, 32'({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy}), 32'd0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_rdata0", 32'(bus.rdata0), 32'd0);
        chk("reset_rdata1", 32'(bus.rdata1), 32'd0);
        sys_rst = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        last_served = 1'b1;
    endtask

    // One isolated transaction; inputs are scrambled and req dropped once granted
    task automatic txn(input bit p, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rd,
                       input string name);
        logic [1:0] gexp;
        gexp = p ? 2'b01 : 2'b10;
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        @(posedge clk);
        #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = ~we;   bus.we1 = ~we;
        bus.addr0 = ~addr; bus.addr1 = ~addr;
        bus.wdata0 = ~wdata; bus.wdata1 = ~wdata;
        @(negedge clk);
        chk({name, "_acc_gnt"}, 32'({bus.gnt0, bus.gnt1}), 32'(gexp));
        chk({name, "_acc_ack"}, 32'({bus.ack0, bus.ack1}), 32'd0);
        chk({name, "_acc_busy"}, 32'(bus.busy), 32'd1);
        if (we) begin
            ref_mem[addr] = wdata;
        end else if (p) begin
            exp_rd1 = exp_rd;
        end else begin
            exp_rd0 = exp_rd;
        end
        @(negedge clk);
        chk({name, "_resp_gnt"}, 32'({bus.gnt0, bus.gnt1}), 32'(gexp));
        chk({name, "_resp_ack"}, 32'({bus.ack0, bus.ack1}), 32'(gexp));
        chk({name, "_rdata0"}, 32'(bus.rdata0), 32'(exp_rd0));
        chk({name, "_rdata1"}, 32'(bus.rdata1), 32'(exp_rd1));
        @(negedge clk);
        chk_quiet({name, "_idle"});
        last_served = p;
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   ack_cyc [$];
        bit   ack_port [$];
        int   cyc_left;
        bit   m_win;
        bit   m_we;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] m_wdata;

        idle_inputs();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;

        vecs[0]  = '{0, 1, 4'd3,  16'h1234, 16'h0000};
        vecs[1]  = '{0, 0, 4'd3,  16'h0000, 16'h1234};
        vecs[2]  = '{1, 1, 4'd15, 16'hBEEF, 16'h0000};
        vecs[3]  = '{0, 0, 4'd15, 16'h0000, 16'hBEEF};
        vecs[4]  = '{1, 1, 4'd0,  16'h0F0F, 16'h0000};
        vecs[5]  = '{1, 0, 4'd0,  16'h0000, 16'h0F0F};
        vecs[6]  = '{0, 1, 4'd0,  16'hA5A5, 16'h0000};
        vecs[7]  = '{1, 0, 4'd0,  16'h0000, 16'hA5A5};
        vecs[8]  = '{1, 0, 4'd3,  16'h0000, 16'h1234};
        vecs[9]  = '{0, 1, 4'd2,  16'h00AA, 16'h0000};
        vecs[10] = '{0, 0, 4'd2,  16'h0000, 16'h00AA};
        vecs[11] = '{0, 0, 4'd15, 16'h0000, 16'hBEEF};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                $sformatf("vec%0d", i));
        end

        // Both requesters held after reset: grants alternate starting with port 0
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 4'd3;
        bus.req1 = 1'b1; bus.addr1 = 4'd15;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("rr_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            if (bus.ack0) begin
                ack_cyc.push_back(k); ack_port.push_back(1'b0);
                chk("rr_rdata0", 32'(bus.rdata0), 32'h1234);
            end
            if (bus.ack1) begin
                ack_cyc.push_back(k); ack_port.push_back(1'b1);
                chk("rr_rdata1", 32'(bus.rdata1), 32'hBEEF);
            end
        end
        idle_inputs();
        exp_rd0 = 16'h1234;
        exp_rd1 = 16'hBEEF;
        last_served = 1'b1;
        chk("rr_count", 32'(ack_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
            chk($sformatf("rr_port%0d", i), 32'(ack_port[i]), 32'(i % 2));
            chk($sformatf("rr_cycle%0d", i), 32'(ack_cyc[i]), 32'(2 + 3 * i));
        end

        // Reset during ACCESS of a write must abort it
        txn(0, 1, 4'd5, 16'h0001, 16'h0000, "pre5");
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd5; bus.wdata0 = 16'h5555;
        @(posedge clk);
        #2;
        sys_rst = 1'b1;
        #1;
        chk_quiet("abort_now");
        chk("abort_rdata0", 32'(bus.rdata0), 32'd0);
        chk("abort_rdata1", 32'(bus.rdata1), 32'd0);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0; last_served = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_quiet("abort_after");
        end
        txn(0, 0, 4'd5, 16'h0000, 16'h0001, "abort_rd5");

        // Fill memory with known values so the random phase has a full reference image
        for (int a = 0; a < DEPTH; a++) begin
            txn(a[0], 1, ADDR_W'(a), DATA_W'($urandom), 16'h0000, "init_wr");
        end

        cyc_left = 0;
        m_win = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        for (int c = 0; c < N_RAND; c++) begin
            bus.req0   = 1'($urandom_range(0, 1));
            bus.req1   = 1'($urandom_range(0, 1));
            bus.we0    = 1'($urandom_range(0, 1));
            bus.we1    = 1'($urandom_range(0, 1));
            bus.addr0  = ADDR_W'($urandom);
            bus.addr1  = ADDR_W'($urandom);
            bus.wdata0 = DATA_W'($urandom);
            bus.wdata1 = DATA_W'($urandom);
            @(posedge clk);
            // Transaction-level reference: a request starts a 2-cycle countdown after IDLE
            if (cyc_left == 0) begin
                if (bus.req0 || bus.req1) begin
                    m_win   = (bus.req0 && bus.req1) ? !last_served : bus.req1;
                    m_we    = m_win ? bus.we1 : bus.we0;
                    m_addr  = m_win ? bus.addr1 : bus.addr0;
                    m_wdata = m_win ? bus.wdata1 : bus.wdata0;
                    cyc_left = 2;
                end
            end else if (cyc_left == 2) begin
                if (m_we) ref_mem[m_addr] = m_wdata;
                else if (m_win) exp_rd1 = ref_mem[m_addr];
                else exp_rd0 = ref_mem[m_addr];
                cyc_left = 1;
            end else begin
                last_served = m_win;
                cyc_left = 0;
            end
            @(negedge clk);
            chk("rand_excl", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            chk($sformatf("rand_ctl_c%0d", c),
                32'({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy}),
                32'({cyc_left != 0 && !m_win, cyc_left != 0 && m_win,
                     cyc_left == 1 && !m_win, cyc_left == 1 && m_win, cyc_left != 0}));
            chk($sformatf("rand_rdata0_c%0d", c), 32'(bus.rdata0), 32'(exp_rd0));
            chk($sformatf("rand_rdata1_c%0d", c), 32'(bus.rdata1), 32'(exp_rd1));
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
